// File: rtl/mips32_reg_dump.sv
// mips32_reg_dump: post-halt register-file readout engine.
// Walks R0..R[DUMP_COUNT-1] through a combinational read port once the core
// halts (or on a manual request) and streams (index, value) words over a
// valid/ready interface. The block is read-only with respect to core state.
module mips32_reg_dump #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DUMP_COUNT = 6
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  input  logic              dump_req,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  // Index of the final register; sized to the counter so DUMP_COUNT equal
  // to 2**ADDR_W compares against all-ones instead of wrapping to zero.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   count, count_next;
  logic                halted_q;
  logic                trigger;
  logic                start;

  logic                valid_next;
  logic [ADDR_W-1:0]   index_next;
  logic [DATA_W-1:0]   data_next;
  logic                last_next;
  logic                busy_next;
  logic                done_next;

  // Halt rising edge; halted_q resets low so a core already halted out of
  // reset still produces a dump.
  assign trigger = halted & ~halted_q;
  assign start   = trigger | dump_req;

  // Read address is only driven with the walk index while reading; the
  // register file sees R0 at all other times.
  assign rf_rd_addr = (state == READ) ? count : '0;

  // Next-state and next-output decode.
  always_comb begin
    state_next = state;
    count_next = count;
    valid_next = dump_valid;
    index_next = dump_index;
    data_next  = dump_data;
    last_next  = dump_last;
    busy_next  = 1'b0;
    done_next  = done;

    unique case (state)
      IDLE: begin
        count_next = '0;
        done_next  = 1'b0;
        if (start) begin
          state_next = READ;
          busy_next  = 1'b1;
        end
      end

      READ: begin
        // Capture the word in the same edge that leaves READ, so the sink
        // sees it registered and independent of the read port afterwards.
        data_next  = rf_rd_data;
        index_next = count;
        last_next  = (count == LAST_IDX);
        valid_next = 1'b1;
        busy_next  = 1'b1;
        state_next = SEND;
      end

      SEND: begin
        busy_next = 1'b1;
        if (dump_ready) begin
          valid_next = 1'b0;
          if (dump_last) begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            count_next = count + ADDR_W'(1);
            state_next = READ;
          end
        end
      end

      DONE: begin
        done_next = 1'b1;
        if (dump_req) begin
          count_next = '0;
          done_next  = 1'b0;
          busy_next  = 1'b1;
          state_next = READ;
        end else if (!halted) begin
          count_next = '0;
          done_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
        done_next  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; all cleared by synchronous reset.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      halted_q   <= 1'b0;
      dump_valid <= 1'b0;
      dump_index <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      halted_q   <= halted;
      dump_valid <= valid_next;
      dump_index <= index_next;
      dump_data  <= data_next;
      dump_last  <= last_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // A stalled word must stay put until the sink takes it.
  a_hold_stable: assert property (@(posedge clk1) disable iff (!rst_n)
    (dump_valid && !dump_ready) |=> (dump_valid && $stable(dump_data) &&
                                     $stable(dump_index) && $stable(dump_last)));

  // In-progress and complete are mutually exclusive.
  a_busy_done: assert property (@(posedge clk1) disable iff (!rst_n)
    !(busy && done));

endmodule

// File: tb/tb_mips32_reg_dump.sv
// Directed bench for mips32_reg_dump: a behavioural register file feeds the
// read port, words are collected at the handshake and compared against
// hand-computed register contents.
module tb_mips32_reg_dump;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        halted;
  logic        dump_req;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        busy;
  logic        done;

  logic        halted32;
  logic        dump_req32;
  logic [4:0]  rf_rd_addr32;
  logic [31:0] rf_rd_data32;
  logic        dump_valid32;
  logic        dump_ready32;
  logic [4:0]  dump_index32;
  logic [31:0] dump_data32;
  logic        dump_last32;
  logic        busy32;
  logic        done32;

  logic [31:0] regs   [32];
  logic [31:0] regs32 [32];

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  got_idx  [$];
  logic [31:0] got_data [$];
  logic        got_last [$];
  int          stable_err;
  int          cap_cycles;
  bit          cap_timeout;

  int stall_tab [8] = '{2, 0, 5, 1, 3, 4, 0, 2};
  logic [31:0] prog_vals [6] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};

  always #5 clk1 = ~clk1;

  assign rf_rd_data   = regs[rf_rd_addr];
  assign rf_rd_data32 = regs32[rf_rd_addr32];

  mips32_reg_dump #(.DATA_W(32), .ADDR_W(5), .DUMP_COUNT(6)) u_dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .dump_req(dump_req),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data), .dump_last(dump_last),
    .busy(busy), .done(done)
  );

  mips32_reg_dump #(.DATA_W(32), .ADDR_W(5), .DUMP_COUNT(32)) u_dut32 (
    .clk1(clk1), .rst_n(rst_n), .halted(halted32), .dump_req(dump_req32),
    .rf_rd_addr(rf_rd_addr32), .rf_rd_data(rf_rd_data32),
    .dump_valid(dump_valid32), .dump_ready(dump_ready32),
    .dump_index(dump_index32), .dump_data(dump_data32), .dump_last(dump_last32),
    .busy(busy32), .done(done32)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Collects words from u_dut until done rises; stall selects the ready
  // pattern and req_at injects a dump_req pulse at that cycle (-1 = none).
  task automatic capture(input int max_cyc, input bit stall, input int req_at);
    int          stalls;
    bit          held;
    logic [31:0] hd;
    logic [4:0]  hi;
    logic        hl;
    int          wno;
    got_idx.delete();
    got_data.delete();
    got_last.delete();
    stable_err  = 0;
    cap_cycles  = max_cyc;
    cap_timeout = 1'b1;
    stalls = 0;
    held   = 1'b0;
    hd = '0; hi = '0; hl = 1'b0;
    wno = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (done === 1'b1) begin
        cap_cycles  = c;
        cap_timeout = 1'b0;
        break;
      end
      if (held && (dump_valid !== 1'b1 || dump_data !== hd ||
                   dump_index !== hi || dump_last !== hl))
        stable_err++;
      if (stall && dump_valid && !held)
        stalls = stall_tab[wno % 8];
      if (stall && dump_valid && stalls > 0) begin
        dump_ready = 1'b0;
        stalls--;
      end else begin
        dump_ready = 1'b1;
      end
      dump_req = (c == req_at);
      if (dump_valid && dump_ready) begin
        got_idx.push_back(dump_index);
        got_data.push_back(dump_data);
        got_last.push_back(dump_last);
        held = 1'b0;
        wno++;
      end else if (dump_valid) begin
        held = 1'b1;
        hd = dump_data; hi = dump_index; hl = dump_last;
      end
      tick();
    end
    dump_req   = 1'b0;
    dump_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dump_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid=%b busy=%b done=%b last=%b, required all 0",
               dump_valid, busy, done, dump_last);
    end
    n_checks++;
    if (dump_index !== 5'd0 || dump_data !== 32'd0 || rf_rd_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data: index=%0d data=%0d addr=%0d, required 0/0/0",
               dump_index, dump_data, rf_rd_addr);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || dump_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: busy=%b valid=%b, required 0/0", busy, dump_valid);
    end
  endtask

  task automatic test_halt_dump();
    int nlast;
    for (int k = 0; k < 32; k++) regs[k] = 32'd0;
    for (int k = 0; k < 6; k++) regs[k] = prog_vals[k];
    halted = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || dump_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_start: busy=%b valid=%b, required 1/0", busy, dump_valid);
    end
    tick();
    n_checks++;
    if (dump_valid !== 1'b1 || dump_index !== 5'd0) begin
      n_fail++;
      $display("FAIL first_latency: valid=%b index=%0d, required 1/0", dump_valid, dump_index);
    end
    capture(60, 1'b0, -1);
    n_checks++;
    if (cap_timeout || got_idx.size() != 6) begin
      n_fail++;
      $display("FAIL halt_count: words=%0d timeout=%0d, required 6/0", got_idx.size(), cap_timeout);
    end
    nlast = 0;
    for (int i = 0; i < got_idx.size() && i < 6; i++) begin
      n_checks++;
      if (got_idx[i] !== 5'(i) || got_data[i] !== prog_vals[i] || got_last[i] !== (i == 5)) begin
        n_fail++;
        $display("FAIL halt_word%0d: (%0d,%0d,last=%b), required (%0d,%0d,last=%b)",
                 i, got_idx[i], got_data[i], got_last[i], i, prog_vals[i], i == 5);
      end
    end
    n_checks++;
    if (cap_cycles != 11) begin
      n_fail++;
      $display("FAIL halt_throughput: %0d cycles, required 11", cap_cycles);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_done: done=%b busy=%b, required 1/0", done, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy === 1'b1 || dump_valid === 1'b1) nlast++;
    end
    n_checks++;
    if (nlast != 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_no_redump: active cycles=%0d done=%b, required 0/1", nlast, done);
    end
  endtask

  task automatic test_stall_dump();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL req_from_done: busy=%b done=%b, required 1/0", busy, done);
    end
    capture(200, 1'b1, -1);
    n_checks++;
    if (cap_timeout || got_idx.size() != 6) begin
      n_fail++;
      $display("FAIL stall_count: words=%0d timeout=%0d, required 6/0", got_idx.size(), cap_timeout);
    end
    for (int i = 0; i < got_idx.size() && i < 6; i++) begin
      n_checks++;
      if (got_idx[i] !== 5'(i) || got_data[i] !== prog_vals[i] || got_last[i] !== (i == 5)) begin
        n_fail++;
        $display("FAIL stall_word%0d: (%0d,%0d,last=%b), required (%0d,%0d,last=%b)",
                 i, got_idx[i], got_data[i], got_last[i], i, prog_vals[i], i == 5);
      end
    end
    n_checks++;
    if (stable_err != 0) begin
      n_fail++;
      $display("FAIL stall_stable: %0d unstable cycles, required 0", stable_err);
    end
  endtask

  task automatic test_manual_req();
    halted = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_to_idle: done=%b busy=%b, required 0/0", done, busy);
    end
    for (int k = 0; k < 32; k++) regs[k] = 32'(k);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    capture(80, 1'b0, 3);
    n_checks++;
    if (cap_timeout || got_idx.size() != 6) begin
      n_fail++;
      $display("FAIL manual_count: words=%0d timeout=%0d, required 6/0", got_idx.size(), cap_timeout);
    end
    for (int i = 0; i < got_idx.size() && i < 6; i++) begin
      n_checks++;
      if (got_idx[i] !== 5'(i) || got_data[i] !== 32'(i)) begin
        n_fail++;
        $display("FAIL manual_word%0d: (%0d,%0d), required (%0d,%0d)",
                 i, got_idx[i], got_data[i], i, i);
      end
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dump_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_settle: done=%b busy=%b valid=%b, required 0/0/0",
               done, busy, dump_valid);
    end
  endtask

  task automatic test_rehalt();
    int nact;
    halted = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rehalt_first_start: busy=%b, required 1", busy);
    end
    capture(80, 1'b0, -1);
    n_checks++;
    if (cap_timeout || got_idx.size() != 6 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL rehalt_first: words=%0d done=%b, required 6/1", got_idx.size(), done);
    end
    halted = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL rehalt_clear: done=%b, required 0", done);
    end
    halted = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rehalt_start: busy=%b done=%b, required 1/0", busy, done);
    end
    capture(80, 1'b0, -1);
    n_checks++;
    if (cap_timeout || got_idx.size() != 6) begin
      n_fail++;
      $display("FAIL rehalt_count: words=%0d timeout=%0d, required 6/0", got_idx.size(), cap_timeout);
    end else begin
      n_checks++;
      if (got_idx[5] !== 5'd5 || got_data[5] !== 32'd5 || got_last[5] !== 1'b1) begin
        n_fail++;
        $display("FAIL rehalt_last: (%0d,%0d,last=%b), required (5,5,last=1)",
                 got_idx[5], got_data[5], got_last[5]);
      end
    end
    nact = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy === 1'b1 || dump_valid === 1'b1) nact++;
    end
    n_checks++;
    if (nact != 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL rehalt_hold: active cycles=%0d done=%b, required 0/1", nact, done);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    dump_req = 1'b1;
    tick();
    dump_req   = 1'b0;
    dump_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (dump_valid === 1'b1 && dump_index === 5'd3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    dump_ready = 1'b0;
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL mid_reach_idx3: found=%0d, required 1", found);
    end
    tick();
    rst_n  = 1'b0;
    halted = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dump_index !== 5'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b busy=%b done=%b index=%0d, required 0/0/0/0",
               dump_valid, busy, done, dump_index);
    end
    dump_ready = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_autostart: busy=%b, required 0", busy);
    end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    n_checks++;
    if (dump_valid !== 1'b1 || dump_index !== 5'd0 || dump_data !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_restart: valid=%b index=%0d data=%0d, required 1/0/0",
               dump_valid, dump_index, dump_data);
    end
    capture(80, 1'b0, -1);
    n_checks++;
    if (cap_timeout || got_idx.size() != 6) begin
      n_fail++;
      $display("FAIL mid_count: words=%0d timeout=%0d, required 6/0", got_idx.size(), cap_timeout);
    end
  endtask

  task automatic test_full_count();
    logic [4:0]  idx [$];
    logic [31:0] dat [$];
    logic        lst [$];
    bit          fin;
    int          nlast;
    for (int k = 0; k < 32; k++) regs32[k] = 32'(k * 3);
    dump_ready32 = 1'b1;
    halted32 = 1'b1;
    fin = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (done32 === 1'b1) begin
        fin = 1'b1;
        break;
      end
      if (dump_valid32 && dump_ready32) begin
        idx.push_back(dump_index32);
        dat.push_back(dump_data32);
        lst.push_back(dump_last32);
      end
      tick();
    end
    n_checks++;
    if (!fin || idx.size() != 32) begin
      n_fail++;
      $display("FAIL full_count: words=%0d finished=%0d, required 32/1", idx.size(), fin);
    end
    nlast = 0;
    for (int i = 0; i < idx.size() && i < 32; i++) begin
      if (lst[i] === 1'b1) nlast++;
      n_checks++;
      if (idx[i] !== 5'(i) || dat[i] !== 32'(i * 3)) begin
        n_fail++;
        $display("FAIL full_word%0d: (%0d,%0d), required (%0d,%0d)",
                 i, idx[i], dat[i], i, i * 3);
      end
    end
    if (idx.size() == 32) begin
      n_checks++;
      if (idx[31] !== 5'd31 || dat[31] !== 32'd93 || lst[31] !== 1'b1 || nlast != 1) begin
        n_fail++;
        $display("FAIL full_last: (%0d,%0d,last=%b) lasts=%0d, required (31,93,last=1) lasts=1",
                 idx[31], dat[31], lst[31], nlast);
      end
    end
    halted32 = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    halted       = 1'b0;
    dump_req     = 1'b0;
    dump_ready   = 1'b1;
    halted32     = 1'b0;
    dump_req32   = 1'b0;
    dump_ready32 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      regs[k]   = 32'd0;
      regs32[k] = 32'd0;
    end
    test_reset();
    test_halt_dump();
    test_stall_dump();
    test_manual_req();
    test_rehalt();
    test_reset_mid();
    test_full_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
